// File: rtl/mac_array_ctrl.sv
// Job sequencer for the mac_tile array: accepts WS/OS jobs, re-arms the array,
// drives west instructions and memory read addresses, and raises output strobes.
module mac_array_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode_sel,
    input  logic [len_bw-1:0]  k_len,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    output logic [1:0]         inst_w,
    output logic               mode,
    output logic               array_rst,
    output logic               xmem_ren,
    output logic [addr_bw-1:0] xmem_addr,
    output logic               feed_zero,
    output logic               ofifo_wr,
    output logic               os_rd,
    output logic               busy,
    output logic               done
);

    // state | meaning
    // IDLE  | waiting for start
    // PREP  | array_rst pulse, job parameters latched
    // LOAD  | WS weight load, col cycles
    // GAP   | one bubble between load and execute
    // EXEC  | activation stream, k_len cycles
    // DRAIN | WS psum drain, row+col cycles
    // SKEW  | OS zero-feed skew flush, row+col-2 cycles
    // RDOUT | OS result readout, row cycles
    // DONE  | one-cycle completion pulse

    localparam int LEN_MAX  = (1 << len_bw) - 1;
    localparam int CNT_MAX  = (LEN_MAX > row + col) ? LEN_MAX : row + col;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int SKEW_LEN = row + col - 2;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [addr_bw-1:0] addr_t;

    localparam cnt_t LOAD_TC  = cnt_t'(col - 1);
    localparam cnt_t DRAIN_TC = cnt_t'(row + col - 1);
    localparam cnt_t SKEW_TC  = cnt_t'((SKEW_LEN > 0) ? SKEW_LEN - 1 : 0);
    localparam cnt_t RDOUT_TC = cnt_t'(row - 1);
    localparam cnt_t ROW_CNT  = cnt_t'(row);
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_PREP, S_LOAD, S_GAP, S_EXEC, S_DRAIN, S_SKEW, S_RDOUT, S_DONE
    } state_t;

    state_t              state, state_nxt;
    cnt_t                cnt, cnt_nxt;
    cnt_t                dly_cnt, dly_nxt;
    cnt_t                wr_cnt, wr_nxt;
    cnt_t                k_tc;
    logic [len_bw-1:0]   k_q;
    addr_t               w_q, x_q, addr_nxt;
    logic [1:0]          inst_w_nxt;
    logic                ofifo_nxt;

    assign k_tc = cnt_t'(k_q) - CNT_ONE;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        addr_nxt  = xmem_addr;
        unique case (state)
            S_IDLE: if (start) state_nxt = S_PREP;
            S_PREP: begin
                if (k_q == '0) begin
                    state_nxt = S_DONE;
                end else if (!mode) begin
                    state_nxt = S_LOAD;
                    cnt_nxt   = LOAD_TC;
                    addr_nxt  = w_q;
                end else begin
                    state_nxt = S_EXEC;
                    cnt_nxt   = k_tc;
                    addr_nxt  = x_q;
                end
            end
            S_LOAD: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                end else begin
                    cnt_nxt  = cnt - CNT_ONE;
                    addr_nxt = xmem_addr + addr_t'(1);
                end
            end
            S_GAP: begin
                state_nxt = S_EXEC;
                cnt_nxt   = k_tc;
                addr_nxt  = x_q;
            end
            S_EXEC: begin
                if (cnt != '0) begin
                    cnt_nxt  = cnt - CNT_ONE;
                    addr_nxt = xmem_addr + addr_t'(1);
                end else if (!mode) begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = DRAIN_TC;
                end else if (SKEW_LEN > 0) begin
                    state_nxt = S_SKEW;
                    cnt_nxt   = SKEW_TC;
                end else begin
                    state_nxt = S_RDOUT;
                    cnt_nxt   = RDOUT_TC;
                end
            end
            S_DRAIN: begin
                if (cnt == '0) state_nxt = S_DONE;
                else           cnt_nxt   = cnt - CNT_ONE;
            end
            S_SKEW: begin
                if (cnt == '0) begin
                    state_nxt = S_RDOUT;
                    cnt_nxt   = RDOUT_TC;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            S_RDOUT: begin
                if (cnt == '0) state_nxt = S_DONE;
                else           cnt_nxt   = cnt - CNT_ONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        inst_w_nxt = 2'b00;
        unique case (state_nxt)
            S_LOAD:         inst_w_nxt = 2'b01;
            S_EXEC, S_SKEW: inst_w_nxt = 2'b10;
            default:        inst_w_nxt = 2'b00;
        endcase
    end

    // psum write window: armed entering WS EXEC, opens row cycles later, lasts k_len cycles
    always_comb begin
        dly_nxt   = dly_cnt;
        wr_nxt    = wr_cnt;
        ofifo_nxt = 1'b0;
        if (state == S_GAP)      dly_nxt = ROW_CNT;
        else if (dly_cnt != '0)  dly_nxt = dly_cnt - CNT_ONE;
        if (dly_cnt == CNT_ONE) begin
            wr_nxt    = cnt_t'(k_q);
            ofifo_nxt = 1'b1;
        end else if (wr_cnt != '0) begin
            wr_nxt    = wr_cnt - CNT_ONE;
            ofifo_nxt = (wr_cnt > CNT_ONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            dly_cnt   <= '0;
            wr_cnt    <= '0;
            k_q       <= '0;
            w_q       <= '0;
            x_q       <= '0;
            mode      <= 1'b0;
            inst_w    <= 2'b00;
            array_rst <= 1'b0;
            xmem_ren  <= 1'b0;
            xmem_addr <= '0;
            feed_zero <= 1'b0;
            ofifo_wr  <= 1'b0;
            os_rd     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dly_cnt   <= dly_nxt;
            wr_cnt    <= wr_nxt;
            xmem_addr <= addr_nxt;
            if (state == S_IDLE && start) begin
                mode <= mode_sel;
                k_q  <= k_len;
                w_q  <= w_base;
                x_q  <= x_base;
            end
            inst_w    <= inst_w_nxt;
            array_rst <= (state_nxt == S_PREP);
            xmem_ren  <= (state_nxt == S_LOAD) || (state_nxt == S_EXEC);
            feed_zero <= (state_nxt == S_SKEW);
            ofifo_wr  <= ofifo_nxt;
            os_rd     <= (state_nxt == S_RDOUT);
            busy      <= (state_nxt != S_IDLE);
            done      <= (state_nxt == S_DONE);
        end
    end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Bench for mac_array_ctrl on a 4x4 array: table of jobs, random jobs, and
// hand sequences for reset abort and start handling, all against a cycle-indexed model.
module tb_mac_array_ctrl;

    localparam int ROW = 4;
    localparam int COL = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode_sel;
    logic [7:0]  k_len;
    logic [10:0] w_base;
    logic [10:0] x_base;
    logic [1:0]  inst_w;
    logic        mode, array_rst, xmem_ren, feed_zero, ofifo_wr, os_rd, busy, done;
    logic [10:0] xmem_addr;

    int n_cmp = 0;
    int n_err = 0;

    mac_array_ctrl #(.row(ROW), .col(COL), .len_bw(8), .addr_bw(11)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_sel(mode_sel), .k_len(k_len),
        .w_base(w_base), .x_base(x_base), .inst_w(inst_w), .mode(mode),
        .array_rst(array_rst), .xmem_ren(xmem_ren), .xmem_addr(xmem_addr),
        .feed_zero(feed_zero), .ofifo_wr(ofifo_wr), .os_rd(os_rd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          m;
        int          k;
        logic [10:0] wb;
        logic [10:0] xb;
        int          exp_len;
    } vec_t;

    vec_t tbl[7];

    function automatic int job_len(bit m, int k);
        if (k == 0) return 2;
        if (!m) return 2 * COL + k + ROW + 3;
        return k + 2 * ROW + COL;
    endfunction

    // expected outputs in cycle c of a job (c=1 is PREP; c outside 1..len is IDLE)
    function automatic logic [20:0] model(bit m, int k, logic [10:0] wb, logic [10:0] xb, int c);
        int          len;
        logic [1:0]  iw;
        logic        ar, ren, fz, ow, rd, bz, dn;
        logic [10:0] a;
        len = job_len(m, k);
        iw = 2'b00; ar = 0; ren = 0; fz = 0; ow = 0; rd = 0; bz = 0; dn = 0; a = '0;
        if (c >= 1 && c <= len) begin
            bz = 1;
            dn = (c == len);
            ar = (c == 1);
            if (k > 0 && !m) begin
                if (c >= 2 && c <= COL + 1) begin
                    iw = 2'b01; ren = 1; a = wb + 11'(c - 2);
                end
                if (c >= COL + 3 && c <= COL + 2 + k) begin
                    iw = 2'b10; ren = 1; a = xb + 11'(c - COL - 3);
                end
                if (c >= COL + 3 + ROW && c <= COL + 2 + ROW + k) ow = 1;
            end else if (k > 0) begin
                if (c >= 2 && c <= k + 1) begin
                    iw = 2'b10; ren = 1; a = xb + 11'(c - 2);
                end
                if (c >= k + 2 && c <= k + ROW + COL - 1) begin
                    iw = 2'b10; fz = 1;
                end
                if (c >= k + ROW + COL && c <= k + 2 * ROW + COL - 1) rd = 1;
            end
        end
        return {iw, m, ar, ren, fz, ow, rd, bz, dn, a};
    endfunction

    function automatic logic [20:0] observed();
        return {inst_w, mode, array_rst, xmem_ren, feed_zero, ofifo_wr, os_rd, busy, done,
                (xmem_ren ? xmem_addr : 11'd0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic accept_job(input bit m, input int k, input logic [10:0] wb, input logic [10:0] xb);
        @(negedge clk);
        start = 1; mode_sel = m; k_len = 8'(k); w_base = wb; x_base = xb;
        @(negedge clk);
        start = 0; mode_sel = ~m; k_len = 8'(k + 7); w_base = ~wb; x_base = ~xb;
    endtask

    task automatic run_job(input bit m, input int k, input logic [10:0] wb, input logic [10:0] xb,
                           input int pulse_c, output int busy_n);
        int len;
        len = job_len(m, k);
        busy_n = 0;
        accept_job(m, k, wb, xb);
        for (int c = 1; c <= len + 2; c++) begin
            check($sformatf("job m=%0d k=%0d cyc %0d", m, k, c), 32'(observed()),
                  32'(model(m, k, wb, xb, c)));
            if (busy) busy_n++;
            start = (c == pulse_c);
            @(negedge clk);
        end
        start = 0;
    endtask

    initial begin
        int busy_n;
        int la, lb;
        bit rm;
        int rk;
        logic [10:0] rw, rx;

        tbl[0] = '{m: 0, k: 3, wb: 11'h010, xb: 11'h040, exp_len: 18};
        tbl[1] = '{m: 1, k: 5, wb: 11'h000, xb: 11'h120, exp_len: 17};
        tbl[2] = '{m: 0, k: 0, wb: 11'h033, xb: 11'h055, exp_len: 2};
        tbl[3] = '{m: 1, k: 0, wb: 11'h000, xb: 11'h077, exp_len: 2};
        tbl[4] = '{m: 1, k: 4, wb: 11'h000, xb: 11'h7FE, exp_len: 16};
        tbl[5] = '{m: 0, k: 4, wb: 11'h7FD, xb: 11'h7FE, exp_len: 19};
        tbl[6] = '{m: 0, k: 1, wb: 11'h200, xb: 11'h300, exp_len: 16};

        reset = 1; start = 0; mode_sel = 0; k_len = '0; w_base = '0; x_base = '0;
        repeat (2) @(negedge clk);
        check("reset state", 32'(observed()), 32'(model(0, 0, '0, '0, 0)));
        check("reset addr", 32'(xmem_addr), 32'd0);
        reset = 0;

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].m, tbl[i].k, tbl[i].wb, tbl[i].xb, 0, busy_n);
            check($sformatf("busy length vec %0d", i), 32'(busy_n), 32'(tbl[i].exp_len));
        end

        // start pulsed during EXEC must not disturb the running job
        run_job(0, 3, 11'h010, 11'h040, COL + 4, busy_n);
        check("busy length exec-pulse ws", 32'(busy_n), 32'd18);
        run_job(1, 5, 11'h000, 11'h040, 3, busy_n);
        check("busy length exec-pulse os", 32'(busy_n), 32'd17);

        // asynchronous reset in the middle of EXEC
        accept_job(0, 10, 11'h0A0, 11'h100);
        for (int c = 1; c <= COL + 5; c++) begin
            check($sformatf("pre-abort cyc %0d", c), 32'(observed()),
                  32'(model(0, 10, 11'h0A0, 11'h100, c)));
            if (c < COL + 5) @(negedge clk);
        end
        #2 reset = 1;
        #1 check("async reset outputs", 32'({observed(), xmem_addr}), 32'd0);
        @(negedge clk);
        reset = 0;
        check("post-reset idle", 32'({observed(), xmem_addr}), 32'd0);
        @(negedge clk);
        check("no done after abort", 32'(observed()), 32'(model(0, 0, '0, '0, 0)));
        run_job(0, 3, 11'h010, 11'h040, 0, busy_n);
        check("busy length after abort", 32'(busy_n), 32'd18);

        // start held high: one IDLE cycle between jobs, mode changes only at PREP
        la = job_len(0, 2);
        lb = job_len(1, 3);
        @(negedge clk);
        start = 1; mode_sel = 0; k_len = 8'd2; w_base = 11'h050; x_base = 11'h060;
        @(negedge clk);
        mode_sel = 1; k_len = 8'd3; w_base = 11'h000; x_base = 11'h3F0;
        for (int c = 1; c <= la + 1; c++) begin
            check($sformatf("held A cyc %0d", c), 32'(observed()),
                  32'(model(0, 2, 11'h050, 11'h060, c)));
            @(negedge clk);
        end
        start = 0;
        for (int c = 1; c <= lb + 1; c++) begin
            check($sformatf("held B cyc %0d", c), 32'(observed()),
                  32'(model(1, 3, 11'h000, 11'h3F0, c)));
            @(negedge clk);
        end

        for (int i = 0; i < 12; i++) begin
            rm = 1'($urandom_range(0, 1));
            rk = int'($urandom_range(0, 12));
            rw = 11'($urandom);
            rx = 11'($urandom);
            run_job(rm, rk, rw, rx, (rk > 0) ? (rm ? 2 : COL + 3) : 0, busy_n);
            check($sformatf("rand busy length %0d", i), 32'(busy_n), 32'(job_len(rm, rk)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
